// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared FSM state type and default widths for the LIF spike decoder
package lif_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } lif_state_t;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 8;

endpackage

// File: rtl/lif_spike_edge.sv
// rtl/lif_spike_edge.sv - spike history register and rising-edge pulse
module lif_spike_edge (
  input  logic clk,
  input  logic rst,
  input  logic spike_in,
  output logic spike_edge
);

  logic spike_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_prev <= 1'b0;
    end else begin
      spike_prev <= spike_in;
    end
  end

  // A spike held high for several cycles yields a single pulse.
  assign spike_edge = spike_in & ~spike_prev;

endmodule

// File: rtl/lif_spike_decoder.sv
// rtl/lif_spike_decoder.sv - LIF spike-rate decoder; optional ISI output via LIF_DEC_ISI_EN
module lif_spike_decoder
  import lif_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             sat,
  output logic             overrun,
  output logic             busy
`ifdef LIF_DEC_ISI_EN
  ,
  output logic [WIN_W-1:0] isi_out,
  output logic             isi_valid
`endif
);

  localparam logic [WIN_W-1:0] W_ONE = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  lif_state_t       state_q, state_d;
  logic             spike_edge;
  logic             start, done;
  logic [WIN_W-1:0] win_left;
  logic [CNT_W-1:0] count, count_next;

  lif_spike_edge u_edge (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .spike_edge (spike_edge)
  );

  // count_next already includes an edge in the current cycle, so the last
  // window cycle can publish it directly.
  assign count_next = (spike_edge && count != C_MAX) ? count + C_ONE : count;
  assign busy       = (state_q == COUNT);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          start   = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (win_left == W_ONE) begin
          done = 1'b1;
          if (en) start = 1'b1;
          else    state_d = IDLE;
        end else if (!en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_left   <= '0;
      count      <= '0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
      sat        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start) begin
        win_left <= (win_len == '0) ? W_ONE : win_len;
        count    <= '0;
      end else if (state_q == COUNT) begin
        if (state_d == IDLE) begin
          win_left <= '0;
          count    <= '0;
        end else begin
          win_left <= win_left - W_ONE;
          count    <= count_next;
        end
      end

      if (state_q == COUNT && spike_edge && count == C_MAX) begin
        sat <= 1'b1;
      end

      // A fresh result wins over an accept in the same cycle; only an
      // unaccepted pending result counts as overwritten.
      if (done) begin
        rate_out   <= count_next;
        rate_valid <= 1'b1;
        if (rate_valid && !rate_ready) overrun <= 1'b1;
      end else if (rate_valid && rate_ready) begin
        rate_valid <= 1'b0;
      end
    end
  end

`ifdef LIF_DEC_ISI_EN
  logic [WIN_W-1:0] isi_cnt;
  logic             isi_armed;

  // Free-running interval counter, independent of the window FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      isi_cnt   <= '0;
      isi_armed <= 1'b0;
      isi_out   <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (spike_edge) begin
        if (isi_armed) begin
          isi_out   <= isi_cnt;
          isi_valid <= 1'b1;
        end
        isi_armed <= 1'b1;
        isi_cnt   <= W_ONE;
      end else if (isi_cnt != {WIN_W{1'b1}}) begin
        isi_cnt <= isi_cnt + W_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lif_spike_decoder.sv
// tb/tb_lif_spike_decoder.sv - directed self-checking bench for lif_spike_decoder
module tb_lif_spike_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       spike_in;
  logic [7:0] win_len;
  logic       rate_ready;

  logic [7:0] rate_out;
  logic       rate_valid, sat, overrun, busy;
  logic [3:0] rate_out4;
  logic       rate_valid4, sat4, overrun4, busy4;
`ifdef LIF_DEC_ISI_EN
  logic [7:0] isi_out, isi_out4;
  logic       isi_valid, isi_valid4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lif_spike_decoder #(.CNT_W(8), .WIN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .win_len    (win_len),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .sat        (sat),
    .overrun    (overrun),
    .busy       (busy)
`ifdef LIF_DEC_ISI_EN
    ,
    .isi_out    (isi_out),
    .isi_valid  (isi_valid)
`endif
  );

  lif_spike_decoder #(.CNT_W(4), .WIN_W(8)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .win_len    (win_len),
    .rate_out   (rate_out4),
    .rate_valid (rate_valid4),
    .rate_ready (rate_ready),
    .sat        (sat4),
    .overrun    (overrun4),
    .busy       (busy4)
`ifdef LIF_DEC_ISI_EN
    ,
    .isi_out    (isi_out4),
    .isi_valid  (isi_valid4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; spike_in = 1'b0; rate_ready = 1'b0; win_len = 8'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rate_out !== 8'd0) begin errors++; $display("FAIL reset_rate_out: got %0d expected 0", rate_out); end
    checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL reset_rate_valid: got %b expected 0", rate_valid); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic_window();
    logic early = 1'b0;
    logic busy_seen = 1'b0;
    do_reset();
    win_len = 8'd10; en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      spike_in = (i == 2 || i == 4 || i == 6);
      tick();
      if (i == 0) busy_seen = busy;
      if (i < 10 && rate_valid) early = 1'b1;
    end
    spike_in = 1'b0;
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_seen); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", early); end
    checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_at_11: got %b expected 1", rate_valid); end
    checks++; if (rate_out !== 8'd3) begin errors++; $display("FAIL basic_rate: got %0d expected 3", rate_out); end
    en = 1'b0; rate_ready = 1'b1;
    tick();
    rate_ready = 1'b0;
    checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b expected 0", rate_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_abort_busy: got %b expected 0", busy); end
  endtask

  task automatic test_held_spike();
    do_reset();
    win_len = 8'd10; en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      spike_in = (i >= 2 && i <= 6);
      tick();
    end
    spike_in = 1'b0; en = 1'b0;
    checks++; if (rate_out !== 8'd1) begin errors++; $display("FAIL held_rate: got %0d expected 1", rate_out); end
  endtask

  task automatic test_saturation();
    do_reset();
    win_len = 8'd40; en = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      spike_in = ((i % 2) == 1) && (i <= 39);
      tick();
    end
    spike_in = 1'b0; en = 1'b0;
    checks++; if (rate_valid4 !== 1'b1) begin errors++; $display("FAIL sat_valid4: got %b expected 1", rate_valid4); end
    checks++; if (rate_out4 !== 4'd15) begin errors++; $display("FAIL sat_rate4: got %0d expected 15", rate_out4); end
    checks++; if (sat4 !== 1'b1) begin errors++; $display("FAIL sat_flag4: got %b expected 1", sat4); end
    checks++; if (rate_out !== 8'd20) begin errors++; $display("FAIL sat_rate8: got %0d expected 20", rate_out); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_flag8: got %b expected 0", sat); end
  endtask

  task automatic test_overrun();
    logic unstable = 1'b0;
    do_reset();
    win_len = 8'd5; en = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      spike_in   = (k == 2 || k == 7 || k == 9 || k == 11 || k == 13 || k == 15);
      rate_ready = (k == 10);
      tick();
      if (k >= 6 && k <= 9 && rate_out !== 8'd1) unstable = 1'b1;
      if (k == 5) begin
        checks++; if (rate_out !== 8'd1) begin errors++; $display("FAIL ovr_first_rate: got %0d expected 1", rate_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag: got %b expected 0", overrun); end
      end
      if (k == 10) begin
        checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL ovr_accept_valid: got %b expected 1", rate_valid); end
        checks++; if (rate_out !== 8'd2) begin errors++; $display("FAIL ovr_accept_rate: got %0d expected 2", rate_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_accept_flag: got %b expected 0", overrun); end
      end
      if (k == 15) begin
        checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL ovr_third_valid: got %b expected 1", rate_valid); end
        checks++; if (rate_out !== 8'd3) begin errors++; $display("FAIL ovr_third_rate: got %0d expected 3", rate_out); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_third_flag: got %b expected 1", overrun); end
      end
    end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL ovr_hold_stable: got %b expected 0", unstable); end
    spike_in = 1'b0; en = 1'b0; rate_ready = 1'b0;
    tick();
    rate_ready = 1'b1;
    tick();
    rate_ready = 1'b0;
    checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b expected 0", rate_valid); end
  endtask

  task automatic test_abort();
    logic seen = 1'b0;
    do_reset();
    win_len = 8'd10; en = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      spike_in = (i == 1);
      tick();
    end
    spike_in = 1'b0; en = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    repeat (12) begin
      tick();
      if (rate_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %b expected 0", seen); end
  endtask

  task automatic test_reset_mid_window();
    do_reset();
    win_len = 8'd4; en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      spike_in = (i == 2 || i == 6);
      tick();
    end
    spike_in = 1'b0;
    checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", rate_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rstmid_pre_overrun: got %b expected 1", overrun); end
    rst = 1'b1;
    tick();
    checks++; if (rate_out !== 8'd0) begin errors++; $display("FAIL rstmid_rate_out: got %0d expected 0", rate_out); end
    checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", rate_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL rstmid_sat: got %b expected 0", sat); end
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_zero_length();
    do_reset();
    win_len = 8'd0; en = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b expected 1", busy); end
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0; en = 1'b0;
    checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b expected 1", rate_valid); end
    checks++; if (rate_out !== 8'd1) begin errors++; $display("FAIL zero_rate: got %0d expected 1", rate_out); end
    tick();
  endtask

`ifdef LIF_DEC_ISI_EN
  task automatic test_isi();
    do_reset();
    for (int k = 0; k <= 11; k++) begin
      spike_in = (k == 3 || k == 10);
      tick();
      if (k == 3) begin
        checks++; if (isi_valid !== 1'b0) begin errors++; $display("FAIL isi_first_edge: got %b expected 0", isi_valid); end
      end
      if (k == 10) begin
        checks++; if (isi_valid !== 1'b1) begin errors++; $display("FAIL isi_valid: got %b expected 1", isi_valid); end
        checks++; if (isi_out !== 8'd7) begin errors++; $display("FAIL isi_out: got %0d expected 7", isi_out); end
      end
      if (k == 11) begin
        checks++; if (isi_valid !== 1'b0) begin errors++; $display("FAIL isi_pulse: got %b expected 0", isi_valid); end
      end
    end
    spike_in = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; spike_in = 1'b0; rate_ready = 1'b0; win_len = 8'd0;
    test_reset();
    test_basic_window();
    test_held_spike();
    test_saturation();
    test_overrun();
    test_abort();
    test_reset_mid_window();
    test_zero_length();
`ifdef LIF_DEC_ISI_EN
    test_isi();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
